regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Shares the single register-file write-back port (wb_en / wb_data / rd_index) among N_REQ result producers, e.g. ALU, load unit and multi-cycle mul/div.
- Each producer presents a result with a valid/ready handshake.
- The block grants one per cycle, round-robin.
- It registers the winning write toward the register file.
- It sits between the execute/memory stages and the register file.

Parameters:
N_REQ, 3, number of write-back requesters (2..8)
DATA_W, 32, write data width
IDX_W, 5, register index width

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-requester result valid
req_rd  in  N_REQ*IDX_W  per-requester destination index, requester i in bits [i*IDX_W +: IDX_W]
req_data  in  N_REQ*DATA_W  per-requester result data, packed the same way
req_ready  out  N_REQ  one-hot grant; requester i accepted when req_valid[i] & req_ready[i]
wb_hold  in  1  blocks all grants this cycle
wb_en  out  1  register-file write enable (registered)
wb_data  out  DATA_W  register-file write data (registered)
rd_index  out  IDX_W  register-file write index (registered)
grant_id  out  clog2(N_REQ)  index of the requester that produced the current wb_* values (registered)

Behaviour:
- Reset (rst_n=0, asynchronous): wb_en=0, wb_data=0, rd_index=0, grant_id=0, rr_ptr=0. req_ready=0 while rst_n=0.
- req_ready is combinational from req_valid, rr_ptr and wb_hold. It is at most one-hot and never asserted for a requester with req_valid=0.
- Arbitration:
  - Search starts at rr_ptr and runs upward, wrapping from N_REQ-1 to 0.
  - The first i with req_valid[i]=1 is granted.
  - After a grant to i, rr_ptr <= (i+1) mod N_REQ.
  - With no grant, rr_ptr holds.
- wb_hold=1: req_ready=0, rr_ptr holds, and wb_en=0 on the next cycle.
- Latency is one cycle. Accept in cycle T gives wb_en=1, wb_data=req_data[i] and rd_index=req_rd[i] in cycle T+1; the register file commits at the edge ending T+1.
- No accept in T: wb_en=0 in T+1. wb_data, rd_index and grant_id hold their previous values.
- rd=0 requests are accepted normally (ready asserted, rr_ptr advances). wb_en stays 0 for them, so x0 is never written.
- Requester protocol:
  - Once valid is asserted, req_rd and req_data are held stable until accepted.
  - Valid is never withdrawn before acceptance.
  - Violations are undefined.
- Two requesters targeting the same rd in one cycle: only the winner writes that cycle. The loser writes in a later cycle, so the last accepted value persists.
- Starvation bound: a requester holding valid is granted within N_REQ grant cycles (cycles with wb_hold=0).
- A reset asserted mid-operation discards any registered write: wb_en drops to 0 immediately and the pending write is lost.
- Throughput is one write per cycle, sustained.

Optional Feature:
Macro WB_ARB_BYPASS_EN.
- When defined, add ports:
  - rs1_index in IDX_W, rs2_index in IDX_W
  - fwd_rs1_hit out 1, fwd_rs1_data out DATA_W
  - fwd_rs2_hit out 1, fwd_rs2_data out DATA_W
- fwd_rsX_hit = wb_en & (rd_index == rsX_index) & (rsX_index != 0), combinational. fwd_rsX_data = wb_data when hit, else 0.
- This covers the cycle in which the register file still returns the old value.
- When undefined, these ports do not exist and there is no forwarding logic.

Test Plan:
1. Reset then single request: valid[1]=1, rd=5, data=0xDEADBEEF -> ready[1]=1 that cycle; next cycle wb_en=1, rd_index=5, wb_data=0xDEADBEEF, grant_id=1; rr_ptr=2.
2. All three valid continuously from reset, rd=1/2/3 -> grants in order 0,1,2,0,…; wb_en=1 every cycle; rd_index sequence 1,2,3.
3. rd=0 request with data 0x1234 -> ready asserted, rr_ptr advances, next cycle wb_en=0.
4. wb_hold=1 for 2 cycles with valid[0]=1 -> ready=0 and wb_en=0 during the hold; ready[0]=1 on the first cycle after release.
5. Requesters 0 and 2 both write rd=7 (0xAAAA / 0xBBBB) with rr_ptr=0 -> 0xAAAA is written first, then 0xBBBB; register 7 ends at 0xBBBB.
6. rst_n pulled low while wb_en=1 -> wb_en=0 asynchronously before the next edge; after release no stale write occurs. With WB_ARB_BYPASS_EN: wb_en=1, rd_index=9, rs1_index=9 -> fwd_rs1_hit=1 and fwd_rs1_data=wb_data; rs2_index=0 -> fwd_rs2_hit=0.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the single register-file write-back port among N_REQ producers.
// Optional macro WB_ARB_BYPASS_EN adds rs1/rs2 forwarding from the registered write.
module regfile_wb_arbiter #(
  parameter int N_REQ  = 3,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*IDX_W-1:0]      req_rd,
  input  logic [N_REQ*DATA_W-1:0]     req_data,
  output logic [N_REQ-1:0]            req_ready,
  input  logic                        wb_hold,
  output logic                        wb_en,
  output logic [DATA_W-1:0]           wb_data,
  output logic [IDX_W-1:0]            rd_index,
  output logic [$clog2(N_REQ)-1:0]    grant_id
`ifdef WB_ARB_BYPASS_EN
  ,
  input  logic [IDX_W-1:0]            rs1_index,
  input  logic [IDX_W-1:0]            rs2_index,
  output logic                        fwd_rs1_hit,
  output logic [DATA_W-1:0]           fwd_rs1_data,
  output logic                        fwd_rs2_hit,
  output logic [DATA_W-1:0]           fwd_rs2_data
`endif
);
  localparam int            GW    = $clog2(N_REQ);
  localparam int            CW    = GW + 1;
  localparam logic [CW-1:0] N_EXT = CW'(N_REQ);
  localparam logic [GW-1:0] LAST  = GW'(N_REQ - 1);

  logic [N_REQ-1:0][IDX_W-1:0]  rd_arr;
  logic [N_REQ-1:0][DATA_W-1:0] data_arr;
  assign rd_arr   = req_rd;
  assign data_arr = req_data;

  logic [GW-1:0] rr_ptr, gnt_idx;
  logic [CW-1:0] cand;
  logic          gnt_any, accept;

  // Search upward from rr_ptr with wrap; one subtraction suffices since rr_ptr < N_REQ.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr} + CW'(k);
      if (cand >= N_EXT) cand = cand - N_EXT;
      if (!gnt_any && req_valid[cand[GW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[GW-1:0];
      end
    end
  end

  assign accept = gnt_any & ~wb_hold;

  always_comb begin
    req_ready = '0;
    if (accept && rst_n) req_ready[gnt_idx] = 1'b1;
  end

  // rd=0 is consumed like any other result but never raises the write enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      wb_en    <= 1'b0;
      wb_data  <= '0;
      rd_index <= '0;
      grant_id <= '0;
    end else begin
      wb_en <= accept && (rd_arr[gnt_idx] != '0);
      if (accept) begin
        rr_ptr   <= (gnt_idx == LAST) ? '0 : gnt_idx + 1'b1;
        wb_data  <= data_arr[gnt_idx];
        rd_index <= rd_arr[gnt_idx];
        grant_id <= gnt_idx;
      end
    end
  end

`ifdef WB_ARB_BYPASS_EN
  assign fwd_rs1_hit  = wb_en && (rd_index == rs1_index) && (rs1_index != '0);
  assign fwd_rs1_data = fwd_rs1_hit ? wb_data : '0;
  assign fwd_rs2_hit  = wb_en && (rd_index == rs2_index) && (rs2_index != '0);
  assign fwd_rs2_data = fwd_rs2_hit ? wb_data : '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed + randomized bench for regfile_wb_arbiter with a queue of expected write-back results.
module tb_regfile_wb_arbiter;
  localparam int N  = 3;
  localparam int DW = 32;
  localparam int IW = 5;
  localparam int GW = $clog2(N);

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*IW-1:0] req_rd = '0;
  logic [N*DW-1:0] req_data = '0;
  logic            wb_hold = 1'b0;
  logic            wb_en;
  logic [DW-1:0]   wb_data;
  logic [IW-1:0]   rd_index;
  logic [GW-1:0]   grant_id;
`ifdef WB_ARB_BYPASS_EN
  logic [IW-1:0]   rs1_index = '0, rs2_index = '0;
  logic            fwd_rs1_hit, fwd_rs2_hit;
  logic [DW-1:0]   fwd_rs1_data, fwd_rs2_data;
`endif

  regfile_wb_arbiter #(.N_REQ(N), .DATA_W(DW), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data), .req_ready(req_ready),
    .wb_hold(wb_hold), .wb_en(wb_en), .wb_data(wb_data), .rd_index(rd_index),
    .grant_id(grant_id)
`ifdef WB_ARB_BYPASS_EN
    , .rs1_index(rs1_index), .rs2_index(rs2_index),
    .fwd_rs1_hit(fwd_rs1_hit), .fwd_rs1_data(fwd_rs1_data),
    .fwd_rs2_hit(fwd_rs2_hit), .fwd_rs2_data(fwd_rs2_data)
`endif
  );

  typedef struct {
    logic          en;
    logic          chk;
    logic [DW-1:0] data;
    logic [IW-1:0] rd;
    logic [GW-1:0] gid;
  } exp_t;

  exp_t          sb[$];
  int            n_cmp = 0, n_bad = 0;
  int            m_ptr;
  logic          m_known;
  logic [DW-1:0] m_data;
  logic [IW-1:0] m_rd;
  logic [GW-1:0] m_gid;
  logic [IW-1:0] t_rd[N];
  logic [DW-1:0] t_dat[N];
  logic [DW-1:0] rf[32];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // After reset the first observed cycle must show no write and zeroed registers.
  task automatic model_reset();
    m_ptr   = 0;
    m_known = 1'b1;
    m_data  = '0;
    m_rd    = '0;
    m_gid   = '0;
    sb.delete();
    sb.push_back('{1'b0, 1'b1, '0, '0, '0});
  endtask

  task automatic step(input logic [N-1:0] v, input logic hold, output int pick);
    exp_t       e;
    logic [N-1:0] exp_rdy;
    for (int i = 0; i < N; i++) begin
      req_rd[i*IW +: IW]   = t_rd[i];
      req_data[i*DW +: DW] = t_dat[i];
    end
    req_valid = v;
    wb_hold   = hold;
    @(negedge clk);
    if (sb.size() == 0) begin
      n_bad++;
      $error("FAIL sb_empty: got no entry expected one");
    end else begin
      e = sb.pop_front();
      chk("wb_en", wb_en, e.en);
      if (e.chk) begin
        chk("wb_data", wb_data, e.data);
        chk("rd_index", rd_index, e.rd);
        chk("grant_id", grant_id, e.gid);
      end
    end
    if (wb_en === 1'b1) rf[rd_index] = wb_data;
    pick = -1;
    if (!hold)
      for (int k = 0; k < N; k++)
        if (pick < 0 && v[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
    exp_rdy = '0;
    if (pick >= 0) exp_rdy[pick] = 1'b1;
    chk("req_ready", req_ready, exp_rdy);
    if (pick >= 0) begin
      m_ptr = (pick + 1) % N;
      if (t_rd[pick] != '0) begin
        m_known = 1'b1;
        m_data  = t_dat[pick];
        m_rd    = t_rd[pick];
        m_gid   = GW'(pick);
      end else begin
        m_known = 1'b0;
      end
      sb.push_back('{t_rd[pick] != '0, m_known, m_data, m_rd, m_gid});
    end else begin
      sb.push_back('{1'b0, m_known, m_data, m_rd, m_gid});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int           p;
    logic [N-1:0] pend;
    for (int i = 0; i < N; i++) begin t_rd[i] = '0; t_dat[i] = '0; end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    req_valid = '1;
    #1;
    chk("rst_wb_en", wb_en, 1'b0);
    chk("rst_wb_data", wb_data, '0);
    chk("rst_rd_index", rd_index, '0);
    chk("rst_grant_id", grant_id, '0);
    chk("rst_ready", req_ready, '0);
    req_valid = '0;
    #10 rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;

    // all three valid continuously: 0,1,2,0,1,2
    t_rd[0] = 5'd1; t_dat[0] = 32'h100;
    t_rd[1] = 5'd2; t_dat[1] = 32'h200;
    t_rd[2] = 5'd3; t_dat[2] = 32'h300;
    for (int c = 0; c < 6; c++) begin
      step(3'b111, 1'b0, p);
      chk("rr_order", p, c % 3);
    end

    // single request on 1, then 0 and 2 together must pick 2 (pointer now 2)
    t_rd[1] = 5'd5; t_dat[1] = 32'hDEADBEEF;
    step(3'b010, 1'b0, p);
    t_rd[0] = 5'd4; t_dat[0] = 32'h44;
    t_rd[2] = 5'd6; t_dat[2] = 32'h66;
    step(3'b101, 1'b0, p);

    // rd=0 request: accepted, no write
    t_rd[2] = 5'd0; t_dat[2] = 32'h1234;
    step(3'b100, 1'b0, p);

    // two requesters target rd 7; last accepted value persists
    t_rd[0] = 5'd7; t_dat[0] = 32'hAAAA;
    t_rd[2] = 5'd7; t_dat[2] = 32'hBBBB;
    step(3'b101, 1'b0, p);
    step(3'b100, 1'b0, p);
    step(3'b000, 1'b0, p);
    chk("rf7_final", rf[7], 32'hBBBB);

    // hold for two cycles, then release
    t_rd[0] = 5'd3; t_dat[0] = 32'h33;
    step(3'b001, 1'b1, p);
    step(3'b001, 1'b1, p);
    step(3'b001, 1'b0, p);

    // registered write to rd 9, then reset while wb_en is high
    t_rd[1] = 5'd9; t_dat[1] = 32'hCAFEF00D;
`ifdef WB_ARB_BYPASS_EN
    rs1_index = 5'd9;
    rs2_index = 5'd0;
`endif
    step(3'b010, 1'b0, p);
    chk("pre_rst_wb_en", wb_en, 1'b1);
`ifdef WB_ARB_BYPASS_EN
    chk("fwd_rs1_hit", fwd_rs1_hit, 1'b1);
    chk("fwd_rs1_data", fwd_rs1_data, 32'hCAFEF00D);
    chk("fwd_rs2_hit", fwd_rs2_hit, 1'b0);
    chk("fwd_rs2_data", fwd_rs2_data, '0);
`endif
    req_valid = 3'b111;
    rst_n = 1'b0;
    #1;
    chk("midrst_wb_en", wb_en, 1'b0);
    chk("midrst_wb_data", wb_data, '0);
    chk("midrst_ready", req_ready, '0);
    req_valid = '0;
    #1 rst_n = 1'b1;
    model_reset();
    step(3'b000, 1'b0, p);
    step(3'b000, 1'b0, p);

    // randomized traffic honouring the hold-until-accepted protocol
    pend = '0;
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i]  = 1'b1;
          t_rd[i]  = IW'($urandom_range(0, 31));
          t_dat[i] = $urandom;
        end
      step(pend, ($urandom_range(0, 5) == 0), p);
      if (p >= 0) pend[p] = 1'b0;
    end
    step(3'b000, 1'b0, p);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
